// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW hazard detection between ID and EXE/MEM, ID-stage
// forwarding selects, multi-cycle flush sequencing after a taken branch and
// a saturating stall-cycle counter.
// Optional feature macro: HAZARD_FORWARD_EN (forwarding path present; only
// load-use hazards stall). Undefined: every RAW hazard stalls, selects = 00.
module hazard_ctrl #(
   parameter int REG_ADDR_W   = 5,
   parameter int FLUSH_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [REG_ADDR_W-1:0] i_src1_id,
   input  logic [REG_ADDR_W-1:0] i_src2_id,
   input  logic                  i_is_imm,
   input  logic                  i_st_or_bne,
   input  logic [REG_ADDR_W-1:0] i_dest_exe,
   input  logic                  i_wb_en_exe,
   input  logic                  i_mem_r_en_exe,
   input  logic [REG_ADDR_W-1:0] i_dest_mem,
   input  logic                  i_wb_en_mem,
   input  logic                  i_branch_taken,
   output logic                  o_stall,
   output logic                  o_flush,
   output logic [1:0]            o_fwd_sel1,
   output logic [1:0]            o_fwd_sel2,
   output logic [CNT_W-1:0]      o_stall_cnt
);

   localparam logic [3:0]       LP_CNT_LOAD = 4'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] LP_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_FLUSH = 1'b1
   } state_t;

   state_t           r_state, w_nxt_state;
   logic [3:0]       r_cnt, w_nxt_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_src2_valid;
   logic w_m1_exe, w_m2_exe, w_m1_mem, w_m2_mem;
   logic w_stall_raw;
   logic [1:0] w_sel1_raw, w_sel2_raw;
   logic w_in_flush;

   // Register 0 is hardwired zero, so it can never carry a real dependency.
   assign w_src2_valid = ~i_is_imm | i_st_or_bne;
   assign w_m1_exe = (i_src1_id != '0) && (i_src1_id == i_dest_exe);
   assign w_m2_exe = w_src2_valid && (i_src2_id != '0) && (i_src2_id == i_dest_exe);
   assign w_m1_mem = (i_src1_id != '0) && (i_src1_id == i_dest_mem);
   assign w_m2_mem = w_src2_valid && (i_src2_id != '0) && (i_src2_id == i_dest_mem);

`ifdef HAZARD_FORWARD_EN
   // Only a load in EXE cannot be bypassed; ALU results forward, EXE over MEM.
   assign w_stall_raw = i_mem_r_en_exe & i_wb_en_exe & (w_m1_exe | w_m2_exe);
   assign w_sel1_raw  = (i_wb_en_exe & ~i_mem_r_en_exe & w_m1_exe) ? 2'b01 :
                        (i_wb_en_mem & w_m1_mem)                    ? 2'b10 : 2'b00;
   assign w_sel2_raw  = (i_wb_en_exe & ~i_mem_r_en_exe & w_m2_exe) ? 2'b01 :
                        (i_wb_en_mem & w_m2_mem)                    ? 2'b10 : 2'b00;
`else
   // No bypass network: any pending write to a read source must stall.
   logic w_unused_mem_r_en;
   assign w_unused_mem_r_en = i_mem_r_en_exe;
   assign w_stall_raw = (i_wb_en_exe & (w_m1_exe | w_m2_exe)) |
                        (i_wb_en_mem & (w_m1_mem | w_m2_mem));
   assign w_sel1_raw  = 2'b00;
   assign w_sel2_raw  = 2'b00;
`endif

   // The ID instruction is being squashed while flushing: no stall, no forward.
   assign w_in_flush = (r_state == S_FLUSH);
   assign o_flush    = w_in_flush;
   assign o_stall    = w_stall_raw & ~w_in_flush;
   assign o_fwd_sel1 = w_in_flush ? 2'b00 : w_sel1_raw;
   assign o_fwd_sel2 = w_in_flush ? 2'b00 : w_sel2_raw;
   assign o_stall_cnt = r_stall_cnt;

   // Flush FSM state and remaining-cycle counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_nxt_state;
         r_cnt   <= w_nxt_cnt;
      end
   end

   // Next-state: a taken branch starts a flush; branches seen in FLUSH are ignored.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (i_branch_taken) begin
               w_nxt_state = S_FLUSH;
               w_nxt_cnt   = LP_CNT_LOAD;
            end
         end
         S_FLUSH: begin
            if (r_cnt == 4'd0) w_nxt_state = S_IDLE;
            else               w_nxt_cnt   = r_cnt - 4'd1;
         end
         default: begin
            w_nxt_state = S_IDLE;
            w_nxt_cnt   = 4'd0;
         end
      endcase
   end

   // Saturating count of stalled cycles for performance debug.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                             r_stall_cnt <= '0;
      else if (o_stall && (r_stall_cnt != '1))  r_stall_cnt <= r_stall_cnt + LP_CNT_ONE;
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (FLUSH_CYCLES=3, CNT_W=2). Expected values
// depend on whether HAZARD_FORWARD_EN is defined for the build.
module tb_hazard_ctrl;

`ifdef HAZARD_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] src1_id, src2_id, dest_exe, dest_mem;
   logic       is_imm, st_or_bne, wb_en_exe, mem_r_en_exe, wb_en_mem, branch_taken;
   logic       stall, flush;
   logic [1:0] fwd_sel1, fwd_sel2;
   logic [1:0] stall_cnt;

   int n_cmp = 0;
   int n_err = 0;
   logic       e_stall = 1'b0;
   logic [1:0] e_cnt   = 2'd0;

   hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(3), .CNT_W(2)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_src1_id(src1_id), .i_src2_id(src2_id),
      .i_is_imm(is_imm), .i_st_or_bne(st_or_bne),
      .i_dest_exe(dest_exe), .i_wb_en_exe(wb_en_exe), .i_mem_r_en_exe(mem_r_en_exe),
      .i_dest_mem(dest_mem), .i_wb_en_mem(wb_en_mem),
      .i_branch_taken(branch_taken),
      .o_stall(stall), .o_flush(flush),
      .o_fwd_sel1(fwd_sel1), .o_fwd_sel2(fwd_sel2),
      .o_stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Checks the combinational outputs of the current cycle and records the
   // expected stall so the counter model can advance at the next edge.
   task automatic chk_comb(input string tag, input logic s, input logic [1:0] f1,
                           input logic [1:0] f2);
      e_stall = s;
      chk({tag, ".stall"}, {31'd0, stall}, {31'd0, s});
      chk({tag, ".sel1"}, {30'd0, fwd_sel1}, {30'd0, f1});
      chk({tag, ".sel2"}, {30'd0, fwd_sel2}, {30'd0, f2});
   endtask

   task automatic tick();
      @(posedge clk);
      if (e_stall && e_cnt != 2'd3) e_cnt = e_cnt + 2'd1;
      @(negedge clk);
   endtask

   task automatic clr_in();
      src1_id = 0; src2_id = 0; dest_exe = 0; dest_mem = 0;
      is_imm = 0; st_or_bne = 0; wb_en_exe = 0; mem_r_en_exe = 0;
      wb_en_mem = 0; branch_taken = 0;
   endtask

   initial begin
      clr_in();
      rst_n = 1'b0;
      branch_taken = 1'b1;
      // Reset held for 3 cycles with a branch pending: must stay IDLE.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         chk("rst.flush", {31'd0, flush}, 32'd0);
         chk("rst.cnt", {30'd0, stall_cnt}, 32'd0);
      end
      branch_taken = 1'b0;
      rst_n = 1'b1;
      #1 chk_comb("idle", 1'b0, 2'b00, 2'b00);
      tick();
      chk("post_rst.flush", {31'd0, flush}, 32'd0);

      // Load-use on src1: stalls in both builds.
      dest_exe = 5; wb_en_exe = 1; mem_r_en_exe = 1; src1_id = 5;
      #1 chk_comb("lduse", 1'b1, 2'b00, 2'b00);
      chk("lduse.cnt0", {30'd0, stall_cnt}, 32'd0);
      tick();
      chk("lduse.cnt1", {30'd0, stall_cnt}, {30'd0, e_cnt});
      chk("lduse.cnt1c", {30'd0, stall_cnt}, 32'd1);

      // ALU result for src2 in both EXE and MEM: EXE wins.
      clr_in();
      dest_exe = 7; wb_en_exe = 1; dest_mem = 7; wb_en_mem = 1; src2_id = 7;
      #1 chk_comb("alu2", !FWD, 2'b00, FWD ? 2'b01 : 2'b00);
      tick();
      // Immediate form: src2 not read.
      is_imm = 1;
      #1 chk_comb("imm2", 1'b0, 2'b00, 2'b00);
      tick();
      // Store/BNE reads src2 despite the immediate.
      st_or_bne = 1;
      #1 chk_comb("st2", !FWD, 2'b00, FWD ? 2'b01 : 2'b00);
      tick();

      // MEM-only producer for src1.
      clr_in();
      dest_mem = 3; wb_en_mem = 1; src1_id = 3;
      #1 chk_comb("mem1", !FWD, FWD ? 2'b10 : 2'b00, 2'b00);
      tick();
      // Register 0 never matches.
      src1_id = 0; dest_mem = 0; dest_exe = 0; wb_en_exe = 1;
      #1 chk_comb("r0", 1'b0, 2'b00, 2'b00);
      tick();
      chk("cnt.acc", {30'd0, stall_cnt}, {30'd0, e_cnt});

      // Branch in the same cycle as a load-use hazard: stall still wins this cycle.
      clr_in();
      dest_exe = 6; wb_en_exe = 1; mem_r_en_exe = 1; src1_id = 6;
      src2_id = 4; dest_mem = 4; wb_en_mem = 1;
      branch_taken = 1;
      #1 chk_comb("br.same", 1'b1, 2'b00, FWD ? 2'b10 : 2'b00);
      chk("br.same.flush", {31'd0, flush}, 32'd0);
      tick();
      branch_taken = 0;
      #1 chk_comb("fl1", 1'b0, 2'b00, 2'b00);
      chk("fl1.flush", {31'd0, flush}, 32'd1);
      tick();
      branch_taken = 1;  // ignored mid-flush
      #1 chk("fl2.flush", {31'd0, flush}, 32'd1);
      e_stall = 1'b0;
      tick();
      branch_taken = 1;  // sampled on the exit edge: ignored
      #1 chk("fl3.flush", {31'd0, flush}, 32'd1);
      chk_comb("fl3", 1'b0, 2'b00, 2'b00);
      tick();
      branch_taken = 0;
      #1 chk("fl_end.flush", {31'd0, flush}, 32'd0);
      chk_comb("fl_end", 1'b1, 2'b00, FWD ? 2'b10 : 2'b00);
      tick();
      chk("fl_idle.flush", {31'd0, flush}, 32'd0);
      chk("fl.cnt", {30'd0, stall_cnt}, {30'd0, e_cnt});

      // Asynchronous reset mid-flush.
      clr_in();
      branch_taken = 1;
      #1 e_stall = 1'b0;
      tick();
      branch_taken = 0;
      #1 chk("ar.flush_on", {31'd0, flush}, 32'd1);
      rst_n = 1'b0;
      #1 chk("ar.flush_off", {31'd0, flush}, 32'd0);
      chk("ar.cnt", {30'd0, stall_cnt}, 32'd0);
      e_cnt = 2'd0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("ar.idle", {31'd0, flush}, 32'd0);

      // Saturation: six stalled cycles with a 2-bit counter -> 1,2,3,3,3,3.
      dest_exe = 9; wb_en_exe = 1; mem_r_en_exe = 1; src2_id = 9;
      for (int i = 0; i < 6; i++) begin
         #1 chk_comb("sat", 1'b1, 2'b00, 2'b00);
         tick();
         chk("sat.cnt", {30'd0, stall_cnt}, (i < 3) ? i + 1 : 3);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule
